// File: rtl/vector_write_back_collector.sv
// Vector write-back collector: packs result elements by data_type into one VLEN buffer and issues a single masked RF write.
// Optional macro VWB_MASK_SKIP_EN: masked-off indices advance without an element handshake.
module vector_write_back_collector #(
    parameter int DATA_LEN    = 32,
    parameter int VECTOR_SIZE = 8,
    parameter int ELEM_LEN    = 64,
    parameter int CNT_WIDTH   = 6
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            rdy_in,
    input  logic                            start,
    input  logic [4:0]                      rd_in,
    input  logic [DATA_LEN-1:0]             length_in,
    input  logic [2:0]                      data_type_in,
    input  logic                            vm_in,
    input  logic [VECTOR_SIZE*DATA_LEN-1:0] mask_in,
    input  logic                            elem_valid,
    input  logic [ELEM_LEN-1:0]             elem_data,
    output logic                            elem_ready,
    output logic                            busy,
    output logic                            done,
    output logic [1:0]                      rf_signal,
    output logic                            write_back_enabled,
    output logic [4:0]                      rf_rd,
    output logic                            rf_vm,
    output logic [DATA_LEN-1:0]             rf_length,
    output logic [2:0]                      rf_data_type,
    output logic [VECTOR_SIZE*DATA_LEN-1:0] rf_mask,
    output logic [VECTOR_SIZE*DATA_LEN-1:0] rf_data,
    input  logic [1:0]                      rf_status
);
    localparam int VLEN   = VECTOR_SIZE * DATA_LEN;
    localparam int NBYTES = VLEN / 8;

    localparam logic [2:0] ONE_BYTE   = 3'd0;
    localparam logic [2:0] TWO_BYTE   = 3'd1;
    localparam logic [2:0] FOUR_BYTE  = 3'd2;
    localparam logic [2:0] EIGHT_BYTE = 3'd3;

    localparam logic [1:0] RF_NOP          = 2'd0;
    localparam logic [1:0] RF_FINISHED     = 2'd1;
    localparam logic [1:0] VECTOR_RF_WRITE = 2'd2;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COLLECT = 2'd1;
    localparam logic [1:0] S_WRITE   = 2'd2;
    localparam logic [1:0] S_WAIT    = 2'd3;

    logic [1:0]           state_reg;
    logic [CNT_WIDTH-1:0] idx_reg;
    logic [VLEN-1:0]      buffer_reg;
    logic [VLEN-1:0]      buffer_next;
    logic [4:0]           rd_reg;
    logic                 vm_reg;
    logic [DATA_LEN-1:0]  len_reg;
    logic [2:0]           type_reg;
    logic [VLEN-1:0]      mask_reg;
    logic                 done_reg;

    logic [DATA_LEN-1:0]  max_len;
    logic [DATA_LEN-1:0]  clamp_len;
    logic [1:0]           type_shift;
    logic [2:0]           ofs_mask;
    logic                 skip_now;
    logic                 accept;
    logic [CNT_WIDTH-1:0] idx_inc;
    logic                 last_idx;

    // Element count that fits in one vector register; unknown types yield 0 so no write happens.
    always_comb begin
        case (data_type_in)
            ONE_BYTE:   max_len = DATA_LEN'(NBYTES);
            TWO_BYTE:   max_len = DATA_LEN'(NBYTES / 2);
            FOUR_BYTE:  max_len = DATA_LEN'(NBYTES / 4);
            EIGHT_BYTE: max_len = DATA_LEN'(NBYTES / 8);
            default:    max_len = '0;
        endcase
        clamp_len = (length_in > max_len) ? max_len : length_in;
    end

    always_comb begin
        case (type_reg)
            TWO_BYTE:   begin type_shift = 2'd1; ofs_mask = 3'd1; end
            FOUR_BYTE:  begin type_shift = 2'd2; ofs_mask = 3'd3; end
            EIGHT_BYTE: begin type_shift = 2'd3; ofs_mask = 3'd7; end
            default:    begin type_shift = 2'd0; ofs_mask = 3'd0; end
        endcase
    end

`ifdef VWB_MASK_SKIP_EN
    assign skip_now = (state_reg == S_COLLECT) && !vm_reg && !mask_reg[idx_reg];
`else
    assign skip_now = 1'b0;
`endif

    assign elem_ready = rdy_in && (state_reg == S_COLLECT) && !skip_now;
    assign accept     = elem_valid && elem_ready;
    assign idx_inc    = idx_reg + 1'b1;
    assign last_idx   = (idx_inc == len_reg[CNT_WIDTH-1:0]);

    // Each buffer byte knows which element and which byte of that element it holds for the latched type.
    genvar gi;
    generate
        for (gi = 0; gi < NBYTES; gi++) begin : g_lane
            localparam logic [CNT_WIDTH-1:0] BYTE_IDX = CNT_WIDTH'(gi);
            logic [CNT_WIDTH-1:0] lane_elem;
            logic [2:0]           lane_ofs;
            assign lane_elem = BYTE_IDX >> type_shift;
            assign lane_ofs  = BYTE_IDX[2:0] & ofs_mask;
            assign buffer_next[gi*8 +: 8] = (accept && (lane_elem == idx_reg))
                                          ? elem_data[{lane_ofs, 3'b000} +: 8]
                                          : buffer_reg[gi*8 +: 8];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= S_IDLE;
            idx_reg    <= '0;
            buffer_reg <= '0;
            rd_reg     <= '0;
            vm_reg     <= 1'b0;
            len_reg    <= '0;
            type_reg   <= '0;
            mask_reg   <= '0;
            done_reg   <= 1'b0;
        end else if (rdy_in) begin
            done_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        rd_reg     <= rd_in;
                        vm_reg     <= vm_in;
                        mask_reg   <= mask_in;
                        type_reg   <= data_type_in;
                        len_reg    <= clamp_len;
                        buffer_reg <= '0;
                        idx_reg    <= '0;
                        if (clamp_len == '0)
                            done_reg  <= 1'b1;
                        else
                            state_reg <= S_COLLECT;
                    end
                end
                S_COLLECT: begin
                    if (accept || skip_now) begin
                        buffer_reg <= buffer_next;
                        idx_reg    <= idx_inc;
                        if (last_idx)
                            state_reg <= S_WRITE;
                    end
                end
                S_WRITE: state_reg <= S_WAIT;
                S_WAIT: begin
                    if (rf_status == RF_FINISHED) begin
                        state_reg <= S_IDLE;
                        done_reg  <= 1'b1;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign busy               = (state_reg != S_IDLE);
    assign done               = done_reg;
    assign write_back_enabled = (state_reg == S_WRITE);
    assign rf_signal          = (state_reg == S_WRITE) ? VECTOR_RF_WRITE : RF_NOP;
    assign rf_rd              = rd_reg;
    assign rf_vm              = vm_reg;
    assign rf_length          = len_reg;
    assign rf_data_type       = type_reg;
    assign rf_mask            = mask_reg;
    assign rf_data            = buffer_reg;
endmodule

// File: tb/tb_vector_write_back_collector.sv
// Bench for vector_write_back_collector: directed table, reset/abort sequences and random transactions vs a lane-level model.
module tb_vector_write_back_collector;
    localparam int DATA_LEN = 32;
    localparam int VLEN     = 256;
    localparam logic [1:0] RF_NOP          = 2'd0;
    localparam logic [1:0] RF_FINISHED     = 2'd1;
    localparam logic [1:0] VECTOR_RF_WRITE = 2'd2;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                rdy_in = 1'b0;
    logic                start = 1'b0;
    logic [4:0]          rd_in = '0;
    logic [DATA_LEN-1:0] length_in = '0;
    logic [2:0]          data_type_in = '0;
    logic                vm_in = 1'b0;
    logic [VLEN-1:0]     mask_in = '0;
    logic                elem_valid = 1'b0;
    logic [63:0]         elem_data = '0;
    logic                elem_ready, busy, done, write_back_enabled, rf_vm;
    logic [1:0]          rf_signal;
    logic [4:0]          rf_rd;
    logic [DATA_LEN-1:0] rf_length;
    logic [2:0]          rf_data_type;
    logic [VLEN-1:0]     rf_mask, rf_data;
    logic [1:0]          rf_status = RF_NOP;

    int checks = 0;
    int errors = 0;

    vector_write_back_collector dut (
        .clk(clk), .rst(rst), .rdy_in(rdy_in), .start(start), .rd_in(rd_in),
        .length_in(length_in), .data_type_in(data_type_in), .vm_in(vm_in), .mask_in(mask_in),
        .elem_valid(elem_valid), .elem_data(elem_data), .elem_ready(elem_ready), .busy(busy),
        .done(done), .rf_signal(rf_signal), .write_back_enabled(write_back_enabled),
        .rf_rd(rf_rd), .rf_vm(rf_vm), .rf_length(rf_length), .rf_data_type(rf_data_type),
        .rf_mask(rf_mask), .rf_data(rf_data), .rf_status(rf_status)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]   dt;
        int           len;
        logic         vm;
        logic [255:0] mask;
        int           gap;
        int           rdy_mode;
        int           fdelay;
        bit           clean;
        int           exp_len;
        int           exp_hs;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_elem_ready"}, 256'(elem_ready), 256'(0));
        chk({tag, "_busy"}, 256'(busy), 256'(0));
        chk({tag, "_done"}, 256'(done), 256'(0));
        chk({tag, "_wbe"}, 256'(write_back_enabled), 256'(0));
        chk({tag, "_rf_signal"}, 256'(rf_signal), 256'(RF_NOP));
        chk({tag, "_rf_rd"}, 256'(rf_rd), 256'(0));
        chk({tag, "_rf_vm"}, 256'(rf_vm), 256'(0));
        chk({tag, "_rf_length"}, 256'(rf_length), 256'(0));
        chk({tag, "_rf_type"}, 256'(rf_data_type), 256'(0));
        chk({tag, "_rf_mask"}, rf_mask, 256'(0));
        chk({tag, "_rf_data"}, rf_data, 256'(0));
    endtask

    task automatic do_reset(input logic rdy, input string tag);
        @(negedge clk);
        rst = 1'b1; rdy_in = rdy; start = 1'b0; elem_valid = 1'b0; rf_status = RF_NOP;
        @(negedge clk);
        check_reset_outputs(tag);
        rst = 1'b0; rdy_in = 1'b1;
    endtask

    // One transaction: model computes clamped length, handshake order and expected lanes;
    // upstream and RF are emulated cycle by cycle. abort_t >= 0 stops early without finishing.
    task automatic run_txn(input logic [2:0] dt, input int len_in, input logic vm,
                           input logic [255:0] mask, input logic [4:0] rd, input int gap,
                           input int rdy_mode, input int fdelay, input bit clean,
                           input int abort_t, input int exp_len_tbl, input int exp_hs_tbl,
                           input string tag);
        logic [63:0]  ev [32];
        logic [255:0] exp_data;
        int           q[$];
        int           maxl, elen, w, exp_hs, hs, wb_cnt, done_cnt, wb_t, done_t, last_acc_t, frz, t;
        bit           wb_seen, wb_prev, done_prev, need, skip_mode;
        int           pick;

`ifdef VWB_MASK_SKIP_EN
        skip_mode = 1'b1;
`else
        skip_mode = 1'b0;
`endif
        maxl = (dt <= 3'd3) ? (32 >> dt) : 0;
        w    = 8 << dt;
        elen = (len_in > maxl) ? maxl : len_in;
        exp_data = '0;
        for (int i = 0; i < 32; i++) ev[i] = {$urandom(), $urandom()};
        for (int i = 0; i < elen; i++) begin
            need = !skip_mode || vm || mask[i];
            if (need) begin
                q.push_back(i);
                for (int b = 0; b < w; b++) exp_data[i*w + b] = ev[i][b];
            end
        end
        exp_hs = q.size();
        if (exp_len_tbl >= 0) elen = exp_len_tbl;
        if (exp_hs_tbl >= 0) exp_hs = exp_hs_tbl;

        hs = 0; wb_cnt = 0; done_cnt = 0; wb_t = -1; done_t = -1; last_acc_t = -1; frz = 0;
        wb_seen = 0; wb_prev = 0; done_prev = 0;

        @(negedge clk);
        start = 1'b1; rd_in = rd; length_in = DATA_LEN'(len_in); data_type_in = dt;
        vm_in = vm; mask_in = mask; rdy_in = 1'b1; elem_valid = 1'b0; rf_status = RF_NOP;

        for (t = 0; t <= 400; t++) begin
            @(negedge clk);
            // start while busy must be ignored; junk on the latch inputs must not leak in
            start        = (elen > 0) && !wb_seen && ($urandom_range(0, 3) == 0);
            rd_in        = 5'($urandom());
            length_in    = DATA_LEN'($urandom_range(0, 40));
            data_type_in = 3'($urandom());
            vm_in        = 1'($urandom());
            case (rdy_mode)
                0: rdy_in = 1'b1;
                1: rdy_in = ($urandom_range(0, 3) != 0);
                default: begin
                    if (t >= 2 && t <= 4) rdy_in = 1'b0;
                    else if (q.size() == 0 && !wb_seen && frz < 3 && elen > 0) begin
                        rdy_in = 1'b0;
                        frz++;
                    end else rdy_in = 1'b1;
                end
            endcase
            elem_valid = (q.size() > 0) && ($urandom_range(0, 99) >= 32'(gap));
            elem_data  = (q.size() > 0) ? ev[q[0]] : {$urandom(), $urandom()};
            if (abort_t < 0 && wb_seen && t >= wb_t + 1 + fdelay) rf_status = RF_FINISHED;
            else begin
                pick = int'($urandom_range(0, 2));
                rf_status = (pick == 0) ? RF_NOP : ((pick == 1) ? 2'd2 : 2'd3);
            end
            #1;
            if (!rdy_in) chk({tag, "_ready_frozen"}, 256'(elem_ready), 256'(0));
            if (elen == 0) chk({tag, "_busy_len0"}, 256'(busy), 256'(0));
            if (elem_valid && elem_ready) begin
                void'(q.pop_front());
                hs++;
                last_acc_t = t;
            end
            if (write_back_enabled && !wb_prev) begin
                wb_cnt++;
                if (!wb_seen) wb_t = t;
                wb_seen = 1;
                chk({tag, "_rf_signal_write"}, 256'(rf_signal), 256'(VECTOR_RF_WRITE));
                chk({tag, "_wb_data"}, rf_data, exp_data);
            end
            if (done && !done_prev) begin
                done_cnt++;
                done_t = t;
            end
            wb_prev   = write_back_enabled;
            done_prev = done;
            if (abort_t >= 0 && t == abort_t) break;
            if (done_cnt > 0) break;
        end
        start = 1'b0;
        if (abort_t >= 0) return;
        if (t > 400) chk({tag, "_timeout"}, 256'(done_cnt), 256'(1));

        rdy_in = 1'b1; elem_valid = 1'b0; rf_status = RF_NOP;
        repeat (2) @(negedge clk);
        #1;
        chk({tag, "_done_pulse"}, 256'(done), 256'(0));
        chk({tag, "_busy_end"}, 256'(busy), 256'(0));
        chk({tag, "_rf_signal_end"}, 256'(rf_signal), 256'(RF_NOP));
        chk({tag, "_rf_length"}, 256'(rf_length), 256'(elen));
        chk({tag, "_rf_data"}, rf_data, exp_data);
        chk({tag, "_rf_mask"}, rf_mask, mask);
        chk({tag, "_rf_rd"}, 256'(rf_rd), 256'(rd));
        chk({tag, "_rf_vm"}, 256'(rf_vm), 256'(vm));
        chk({tag, "_rf_type"}, 256'(rf_data_type), 256'(dt));
        chk({tag, "_handshakes"}, 256'(hs), 256'(exp_hs));
        chk({tag, "_writes"}, 256'(wb_cnt), 256'((elen > 0) ? 1 : 0));
        chk({tag, "_dones"}, 256'(done_cnt), 256'(1));
        if (elen == 0) chk({tag, "_done_t_len0"}, 256'(done_t), 256'(0));
        if (clean && elen > 0) begin
            chk({tag, "_write_latency"}, 256'(wb_t), 256'(last_acc_t + 1));
            chk({tag, "_done_latency"}, 256'(done_t), 256'(wb_t + 2 + fdelay));
        end
        $display("txn %s: type=%0d len=%0d vm=%0d hs=%0d writes=%0d rf_length=%0d", tag, dt, len_in, vm, hs, wb_cnt, rf_length);
    endtask

    initial begin
        logic [255:0] rmask;
        int           skip_hs;
`ifdef VWB_MASK_SKIP_EN
        skip_hs = 2;
`else
        skip_hs = 4;
`endif
        //          dt     len vm    mask             gap rdy fd clean exp_len exp_hs
        tbl[0] = '{3'd2,   8, 1'b1, {256{1'b1}},      0,  0, 0, 1'b1, 8,  8};
        tbl[1] = '{3'd0,  40, 1'b1, {256{1'b1}},      0,  0, 0, 1'b1, 32, 32};
        tbl[2] = '{3'd3,   5, 1'b1, {256{1'b1}},      0,  0, 0, 1'b1, 4,  4};
        tbl[3] = '{3'd2,   0, 1'b1, {256{1'b1}},      0,  0, 0, 1'b1, 0,  0};
        tbl[4] = '{3'd1,   4, 1'b1, {256{1'b1}},     40,  2, 1, 1'b0, 4,  4};
        tbl[5] = '{3'd2,   4, 1'b0, 256'h5,           0,  0, 0, 1'b0, 4,  skip_hs};
        tbl[6] = '{3'd5,   4, 1'b1, {256{1'b1}},      0,  0, 0, 1'b1, 0,  0};
        tbl[7] = '{3'd3,   4, 1'b0, 256'hA,          30,  1, 2, 1'b0, 4,  skip_hs};

        rst = 1'b1; rdy_in = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        for (int i = 0; i < 8; i++)
            run_txn(tbl[i].dt, tbl[i].len, tbl[i].vm, tbl[i].mask, 5'(i + 3), tbl[i].gap,
                    tbl[i].rdy_mode, tbl[i].fdelay, tbl[i].clean, -1,
                    tbl[i].exp_len, tbl[i].exp_hs, $sformatf("tbl%0d", i));

        // reset mid-COLLECT, with rdy_in low during reset
        run_txn(3'd2, 8, 1'b1, {256{1'b1}}, 5'd9, 0, 0, 0, 1'b0, 3, -1, -1, "abort_collect");
        chk("abort_collect_busy", 256'(busy), 256'(1));
        do_reset(1'b0, "rst_collect");
        run_txn(3'd2, 6, 1'b1, {256{1'b1}}, 5'd10, 0, 0, 0, 1'b1, -1, 6, 6, "after_rst_collect");

        // reset in WAIT: write seen at t=4, RF never finishes
        run_txn(3'd3, 4, 1'b1, {256{1'b1}}, 5'd11, 0, 0, 0, 1'b0, 7, -1, -1, "abort_wait");
        chk("abort_wait_busy", 256'(busy), 256'(1));
        chk("abort_wait_wbe", 256'(write_back_enabled), 256'(0));
        do_reset(1'b1, "rst_wait");
        run_txn(3'd1, 16, 1'b1, {256{1'b1}}, 5'd12, 0, 0, 0, 1'b1, -1, 16, 16, "after_rst_wait");

        for (int n = 0; n < 40; n++) begin
            for (int k = 0; k < 8; k++) rmask[k*32 +: 32] = $urandom();
            run_txn(($urandom_range(0, 9) == 0) ? 3'd6 : 3'($urandom_range(0, 3)),
                    int'($urandom_range(0, 40)), 1'($urandom()), rmask, 5'($urandom()),
                    int'($urandom_range(0, 50)), int'($urandom_range(0, 1)),
                    int'($urandom_range(0, 3)), 1'b0, -1, -1, -1, $sformatf("rand%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
